regfile_wb_ctrl: RTL and testbench

Write-back controller for the 32×32 register file. It shares the file's single write port between two write-back requesters, ALU/immediate (port 0) and load/multi-cycle unit (port 1), using round-robin arbitration and a registered write stage. It also keeps a per-register pending-write scoreboard so the issue stage can stall on operands that are still in flight. It sits between the execute/memory stages and the register file write port (`rg_wrt_en`/`rg_wrt_addr`/`rg_wrt_data`).

---
 rtl/rf_pkg.sv | 17 +
 rtl/rr_arb2.sv | 48 ++++
 rtl/regfile_wb_ctrl.sv | 98 +++++++++
 tb/tb_regfile_wb_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared definitions for the register-file write-back path.
//   DATA_W / ADDR_W : default data and register-address widths
//   ZERO_REG        : hardwired-zero register index
//   wb_req_t        : one write-back request (valid, destination, data)
package rf_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned ZERO_REG = 0;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
//   clk, reset : clock, synchronous active-high reset
//   req[1:0]   : request per port
//   hold       : suppress all grants while high
//   gnt[1:0]   : one-hot grant, combinational from req/hold/last_gnt
// On a tie the port not granted last wins; last_gnt resets to 1 so port 0
// wins the first tie.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       hold,
    output logic [1:0] gnt
);

    logic last_gnt_q, last_gnt_d;

    always_comb begin
        gnt = 2'b00;
        // Nothing is granted during reset so an in-flight request is dropped.
        if (!reset && !hold) begin
            unique case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = last_gnt_q ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    always_comb begin
        last_gnt_d = last_gnt_q;
        if (gnt[0]) begin
            last_gnt_d = 1'b0;
        end else if (gnt[1]) begin
            last_gnt_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_gnt_q <= 1'b1;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Write-back controller for the register file write port.
//   wb0_* : ALU/immediate requester (valid/addr/data in, ready out)
//   wb1_* : load/multi-cycle requester (valid/addr/data in, ready out)
//   wb_hold                 : freeze all grants
//   sb_set_valid/sb_set_addr: mark a destination register pending
//   sb_q_addr1/2, sb_busy1/2: combinational pending-write lookup
//   rg_wrt_en/addr/data     : registered register-file write port
module regfile_wb_ctrl #(
    parameter int unsigned DATA_W = rf_pkg::DATA_W,
    parameter int unsigned ADDR_W = rf_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb0_valid,
    input  logic [ADDR_W-1:0] wb0_addr,
    input  logic [DATA_W-1:0] wb0_data,
    output logic              wb0_ready,
    input  logic              wb1_valid,
    input  logic [ADDR_W-1:0] wb1_addr,
    input  logic [DATA_W-1:0] wb1_data,
    output logic              wb1_ready,
    input  logic              wb_hold,
    input  logic              sb_set_valid,
    input  logic [ADDR_W-1:0] sb_set_addr,
    input  logic [ADDR_W-1:0] sb_q_addr1,
    input  logic [ADDR_W-1:0] sb_q_addr2,
    output logic              sb_busy1,
    output logic              sb_busy2,
    output logic              rg_wrt_en,
    output logic [ADDR_W-1:0] rg_wrt_addr,
    output logic [DATA_W-1:0] rg_wrt_data
);

    import rf_pkg::*;

    localparam int unsigned NumRegs = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZeroAddr = ADDR_W'(ZERO_REG);

    logic [1:0]        gnt;
    logic              xfer;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;

    logic [NumRegs-1:0] busy_q, busy_d;

    rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   ({wb1_valid, wb0_valid}),
        .hold  (wb_hold),
        .gnt   (gnt)
    );

    assign wb0_ready = gnt[0];
    assign wb1_ready = gnt[1];
    assign xfer      = |gnt;
    assign win_addr  = gnt[1] ? wb1_addr : wb0_addr;
    assign win_data  = gnt[1] ? wb1_data : wb0_data;

    // Write stage: register-0 writes are accepted but never enabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            rg_wrt_en   <= 1'b0;
            rg_wrt_addr <= '0;
            rg_wrt_data <= '0;
        end else begin
            rg_wrt_en <= xfer && (win_addr != ZeroAddr);
            if (xfer) begin
                rg_wrt_addr <= win_addr;
                rg_wrt_data <= win_data;
            end
        end
    end

    // Clear first, then set: a newly issued producer overrides a retiring one.
    always_comb begin
        busy_d = busy_q;
        if (rg_wrt_en) begin
            busy_d[rg_wrt_addr] = 1'b0;
        end
        if (sb_set_valid && (sb_set_addr != ZeroAddr)) begin
            busy_d[sb_set_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign sb_busy1 = busy_q[sb_q_addr1];
    assign sb_busy2 = busy_q[sb_q_addr2];

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for regfile_wb_ctrl with a scoreboard: stimulus pushes
// expected grants and register-file writes; a monitor pops and compares.
module tb_regfile_wb_ctrl;

    import rf_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              wb0_valid, wb1_valid;
    logic [ADDR_W-1:0] wb0_addr, wb1_addr;
    logic [DATA_W-1:0] wb0_data, wb1_data;
    logic              wb0_ready, wb1_ready;
    logic              wb_hold;
    logic              sb_set_valid;
    logic [ADDR_W-1:0] sb_set_addr, sb_q_addr1, sb_q_addr2;
    logic              sb_busy1, sb_busy2;
    logic              rg_wrt_en;
    logic [ADDR_W-1:0] rg_wrt_addr;
    logic [DATA_W-1:0] rg_wrt_data;

    int checks = 0;
    int errors = 0;

    wb_req_t exp_wr_q[$];
    int      exp_gnt_q[$];

    always #5 clk = ~clk;

    regfile_wb_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .wb0_valid    (wb0_valid),
        .wb0_addr     (wb0_addr),
        .wb0_data     (wb0_data),
        .wb0_ready    (wb0_ready),
        .wb1_valid    (wb1_valid),
        .wb1_addr     (wb1_addr),
        .wb1_data     (wb1_data),
        .wb1_ready    (wb1_ready),
        .wb_hold      (wb_hold),
        .sb_set_valid (sb_set_valid),
        .sb_set_addr  (sb_set_addr),
        .sb_q_addr1   (sb_q_addr1),
        .sb_q_addr2   (sb_q_addr2),
        .sb_busy1     (sb_busy1),
        .sb_busy2     (sb_busy2),
        .rg_wrt_en    (rg_wrt_en),
        .rg_wrt_addr  (rg_wrt_addr),
        .rg_wrt_data  (rg_wrt_data)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic push_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wb_req_t r;
        r.valid = 1'b1;
        r.addr  = a;
        r.data  = d;
        exp_wr_q.push_back(r);
    endtask

    // Monitor: compares every presented write and every handshake.
    initial begin
        wb_req_t e;
        int      g;
        forever begin
            @(negedge clk);
            if (rg_wrt_en === 1'b1) begin
                if (exp_wr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %0d data 0x%0h expected none",
                             rg_wrt_addr, rg_wrt_data);
                end else begin
                    e = exp_wr_q.pop_front();
                    chk("wr_addr", 64'(rg_wrt_addr), 64'(e.addr));
                    chk("wr_data", 64'(rg_wrt_data), 64'(e.data));
                end
            end
            if (wb0_valid && wb0_ready) begin
                if (exp_gnt_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_gnt0: got grant port 0 expected none");
                end else begin
                    g = exp_gnt_q.pop_front();
                    chk("gnt_port", 64'(0), 64'(g));
                end
            end
            if (wb1_valid && wb1_ready) begin
                if (exp_gnt_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_gnt1: got grant port 1 expected none");
                end else begin
                    g = exp_gnt_q.pop_front();
                    chk("gnt_port", 64'(1), 64'(g));
                end
            end
            if (wb0_valid && wb1_valid) begin
                chk("one_ready", 64'(wb0_ready & wb1_ready), 64'(0));
            end
        end
    end

    initial begin
        reset        = 1'b1;
        wb0_valid    = 1'b0;
        wb1_valid    = 1'b0;
        wb0_addr     = '0;
        wb1_addr     = '0;
        wb0_data     = '0;
        wb1_data     = '0;
        wb_hold      = 1'b0;
        sb_set_valid = 1'b0;
        sb_set_addr  = '0;
        sb_q_addr1   = 5'd7;
        sb_q_addr2   = 5'd9;

        // Reset state
        step();
        reset = 1'b0;
        chk("rst_en", 64'(rg_wrt_en), 64'(0));
        chk("rst_addr", 64'(rg_wrt_addr), 64'(0));
        chk("rst_data", 64'(rg_wrt_data), 64'(0));
        chk("rst_busy1", 64'(sb_busy1), 64'(0));

        // Single write
        wb0_valid = 1'b1;
        wb0_addr  = 5'd5;
        wb0_data  = 32'hDEADBEEF;
        exp_gnt_q.push_back(0);
        push_wr(5'd5, 32'hDEADBEEF);
        #1 chk("single_ready", 64'(wb0_ready), 64'(1));
        step();
        wb0_valid = 1'b0;
        chk("single_en", 64'(rg_wrt_en), 64'(1));
        chk("single_addr", 64'(rg_wrt_addr), 64'(5));
        chk("single_data", 64'(rg_wrt_data), 64'(32'hDEADBEEF));
        step();
        chk("single_en_off", 64'(rg_wrt_en), 64'(0));

        // Contention: grants alternate 0,1,0,1
        do_reset();
        wb0_valid = 1'b1;
        wb0_addr  = 5'd3;
        wb0_data  = 32'hA0A0_0003;
        wb1_valid = 1'b1;
        wb1_addr  = 5'd4;
        wb1_data  = 32'hB0B0_0004;
        for (int i = 0; i < 4; i++) begin
            exp_gnt_q.push_back(i % 2);
            if (i % 2 == 0) push_wr(5'd3, 32'hA0A0_0003);
            else            push_wr(5'd4, 32'hB0B0_0004);
        end
        for (int i = 0; i < 4; i++) begin
            #1 chk("cont_ready0", 64'(wb0_ready), 64'((i % 2) == 0));
            step();
        end
        wb0_valid = 1'b0;
        wb1_valid = 1'b0;

        // Zero register: accepted, never written
        sb_q_addr1 = 5'd0;
        wb1_valid  = 1'b1;
        wb1_addr   = 5'd0;
        wb1_data   = 32'h0000_1234;
        exp_gnt_q.push_back(1);
        #1 chk("zero_ready", 64'(wb1_ready), 64'(1));
        chk("zero_busy_a", 64'(sb_busy1), 64'(0));
        step();
        wb1_valid = 1'b0;
        step();
        chk("zero_busy_b", 64'(sb_busy1), 64'(0));
        step();
        chk("zero_en", 64'(rg_wrt_en), 64'(0));

        // Scoreboard set then clear by a port 1 write
        sb_q_addr1   = 5'd7;
        sb_set_valid = 1'b1;
        sb_set_addr  = 5'd7;
        #1 chk("sb_pre_set", 64'(sb_busy1), 64'(0));
        step();
        sb_set_valid = 1'b0;
        chk("sb_set_c1", 64'(sb_busy1), 64'(1));
        step();
        chk("sb_set_c2", 64'(sb_busy1), 64'(1));
        step();
        wb1_valid = 1'b1;
        wb1_addr  = 5'd7;
        wb1_data  = 32'h7777_0001;
        exp_gnt_q.push_back(1);
        push_wr(5'd7, 32'h7777_0001);
        chk("sb_set_c3", 64'(sb_busy1), 64'(1));
        step();
        wb1_valid = 1'b0;
        chk("sb_wr_cycle", 64'(sb_busy1), 64'(1));
        step();
        chk("sb_cleared", 64'(sb_busy1), 64'(0));

        // Set on the same edge as the clear: set wins
        sb_set_valid = 1'b1;
        step();
        sb_set_valid = 1'b0;
        chk("sb2_set", 64'(sb_busy1), 64'(1));
        wb1_valid = 1'b1;
        wb1_data  = 32'h7777_0002;
        exp_gnt_q.push_back(1);
        push_wr(5'd7, 32'h7777_0002);
        step();
        wb1_valid    = 1'b0;
        sb_set_valid = 1'b1;
        step();
        sb_set_valid = 1'b0;
        chk("sb2_set_wins", 64'(sb_busy1), 64'(1));

        // Hold with both ports valid
        do_reset();
        wb_hold   = 1'b1;
        wb0_valid = 1'b1;
        wb0_addr  = 5'd10;
        wb0_data  = 32'h1010_1010;
        wb1_valid = 1'b1;
        wb1_addr  = 5'd11;
        wb1_data  = 32'h1111_1111;
        for (int i = 0; i < 3; i++) begin
            #1 chk("hold_ready0", 64'(wb0_ready), 64'(0));
            chk("hold_ready1", 64'(wb1_ready), 64'(0));
            chk("hold_en", 64'(rg_wrt_en), 64'(0));
            step();
        end
        wb_hold = 1'b0;
        exp_gnt_q.push_back(0);
        push_wr(5'd10, 32'h1010_1010);
        #1 chk("rel_ready0", 64'(wb0_ready), 64'(1));
        step();
        wb_hold = 1'b1;
        #1 chk("midhold_ready1", 64'(wb1_ready), 64'(0));
        chk("midhold_en", 64'(rg_wrt_en), 64'(1));
        chk("midhold_addr", 64'(rg_wrt_addr), 64'(10));
        step();
        chk("midhold_en_off", 64'(rg_wrt_en), 64'(0));
        wb0_valid = 1'b0;
        wb1_valid = 1'b0;
        wb_hold   = 1'b0;

        // Reset while busy[9]=1 and a write is in flight
        sb_q_addr2   = 5'd9;
        sb_set_valid = 1'b1;
        sb_set_addr  = 5'd9;
        step();
        sb_set_valid = 1'b0;
        chk("rst2_busy9", 64'(sb_busy2), 64'(1));
        wb0_valid = 1'b1;
        wb0_addr  = 5'd2;
        wb0_data  = 32'h2222_2222;
        exp_gnt_q.push_back(0);
        push_wr(5'd2, 32'h2222_2222);
        step();
        chk("rst2_en_pre", 64'(rg_wrt_en), 64'(1));
        reset     = 1'b1;
        wb1_valid = 1'b1;
        wb1_addr  = 5'd12;
        wb1_data  = 32'h1212_1212;
        #1 chk("rst2_ready0", 64'(wb0_ready), 64'(0));
        chk("rst2_ready1", 64'(wb1_ready), 64'(0));
        step();
        reset = 1'b0;
        chk("rst2_en", 64'(rg_wrt_en), 64'(0));
        chk("rst2_addr", 64'(rg_wrt_addr), 64'(0));
        chk("rst2_data", 64'(rg_wrt_data), 64'(0));
        chk("rst2_busy", 64'(sb_busy2), 64'(0));
        exp_gnt_q.push_back(0);
        push_wr(5'd2, 32'h2222_2222);
        #1 chk("rst2_tie0", 64'(wb0_ready), 64'(1));
        chk("rst2_tie1", 64'(wb1_ready), 64'(0));
        step();
        wb0_valid = 1'b0;
        wb1_valid = 1'b0;
        step();
        step();

        chk("wr_queue_empty", 64'(exp_wr_q.size()), 64'(0));
        chk("gnt_queue_empty", 64'(exp_gnt_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
